tx_config_sequencer: RTL and testbench
======================================

# tx_config_sequencer

Run-time configuration sequencer for the `tx_core` transmit DSP path. It accepts configuration requests over a valid/ready handshake and drives `mixer_gain`, `lo_dds_phase_inc`, `enable_pre_distortion` and `scale_select` into `tx_core`. Retunes are glitch-free: the gain fades to zero, the new LO/pre-distortion/scale settings are applied, the path is allowed to flush, then the gain ramps to its target. It also provides a soft mute.

## Interface
Parameters:
- `GAIN_STEP`, 1: gain change per ramp step (1..255).
- `STEP_INTERVAL`, 16: clock cycles between ramp steps (≥1).
- `SETTLE_CYCLES`, 64: cycles held at zero gain after new settings are applied (≥1). Covers `tx_core` pipeline flush.

Ports (one clock; reset is asynchronous and active-low):
- `clock` in 1: datapath clock, shared with `tx_core`.
- `reset_n` in 1: asynchronous active-low reset.
- `cfg_valid` in 1: configuration request valid.
- `cfg_ready` out 1: high only in IDLE.
- `cfg_mixer_gain` in 8: target gain.
- `cfg_lo_dds_phase_inc` in 16: target LO phase increment.
- `cfg_enable_pre_distortion` in 1: target pre-distortion enable.
- `cfg_scale_select` in 4: target output scale.
- `mute_request` in 1: level-sensitive; forces the effective gain target to 0.
- `busy` out 1: state ≠ IDLE.
- `cfg_done` out 1: one-cycle pulse when an accepted configuration is fully applied.
- `mixer_gain` out 8: to `tx_core`.
- `lo_dds_phase_inc` out 16: to `tx_core`.
- `enable_pre_distortion` out 1: to `tx_core`.
- `scale_select` out 4: to `tx_core`.

## Operation
- Shadow registers hold the last accepted request. Accept occurs when `cfg_valid && cfg_ready`.
- Effective gain target: `mute_request ? 0 : shadow_gain`.
- States: IDLE, FADE_OUT, APPLY, SETTLE, TRACK.
- IDLE:
  - If a request is accepted and its phase_inc/pre-distortion/scale all equal the current outputs, go to TRACK (gain-only change).
  - If a request is accepted and any of those fields differ, go to FADE_OUT.
  - With no accept, if `mixer_gain` ≠ effective target (a mute toggle), go to TRACK without setting pending.
  - Accept has priority over the mute mismatch.
- FADE_OUT: ramp toward 0. When `mixer_gain` = 0, go to APPLY. Mute has no effect here.
- APPLY: one cycle. Copy shadow phase_inc/pre-distortion/scale to the outputs. Go to SETTLE.
- SETTLE: hold gain at 0 for SETTLE_CYCLES cycles, then go to TRACK.
- TRACK: ramp toward the effective target. This is re-evaluated every step, so mute asserted mid-ramp reverses the ramp toward 0. When `mixer_gain` = effective target, go to IDLE.
- `pending` flag:
  - Set on accept.
  - On the TRACK→IDLE transition, if `pending` is set: pulse `cfg_done` and clear `pending`.
- Ramp step rule (unsigned 8-bit):
  - If |target − gain| ≤ GAIN_STEP, gain := target.
  - Otherwise gain := gain ± GAIN_STEP.
  - No overshoot, no wrap.
- Step timer:
  - Reloads to STEP_INTERVAL−1 on entry to FADE_OUT or TRACK.
  - A step occurs at terminal count, then the timer reloads.
  - The first step occurs STEP_INTERVAL cycles after entry.
- A request identical to the current state goes to TRACK, which exits immediately.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, shadow and `pending` cleared. At reset release `cfg_ready` = 1, `busy` = 0, `cfg_done` = 0.
- Reset mid-operation: asynchronous. Outputs return to reset values immediately. No `cfg_done` is issued for the aborted request.
- Accept at edge c: state is TRACK or FADE_OUT in cycle c+1, and `cfg_ready` is low from c+1.
- New phase_inc/pd/scale are visible the cycle after APPLY, which is the first SETTLE cycle.
- Gain stays 0 from the last FADE_OUT step until the first TRACK step. That covers the APPLY cycle, then SETTLE_CYCLES cycles, then STEP_INTERVAL cycles.
- `cfg_done` is asserted in the first IDLE cycle. `cfg_ready` is high in the same cycle.
- For an identical request accepted at c: `cfg_done` at c+2.
- Full retune from gain G to target T:
  - Ramp-down: ceil(G/GAIN_STEP)·STEP_INTERVAL cycles.
  - Then 1 (APPLY) + SETTLE_CYCLES.
  - Then ramp-up: ceil(T/GAIN_STEP)·STEP_INTERVAL cycles.
  - Plus one transition cycle per state change.

## Structure
- `tx_ctrl_pkg`:
  - `tx_seq_state_t` enum.
  - `tx_cfg_t` packed struct: gain, phase_inc, pre-distortion, scale.
  - Field width localparams: 8/16/1/4.
- Sub-module `gain_ramp`:
  - Contains the step timer and the saturating stepper.
  - Inputs: `start` (timer reload), `enable`, target, current gain.
  - Outputs: next gain, `at_target`.
- The top level owns the FSM, shadow registers, handshake and `pending`.

## Test plan
Bench parameters for all scenarios: GAIN_STEP=8, STEP_INTERVAL=4, SETTLE_CYCLES=10.

1. **Reset values.** Assert `reset_n`=0 mid-ramp → all outputs 0 immediately. Release reset → `cfg_ready`=1 and `busy`=0.
2. **Gain-only change.** From reset, accept gain=0x20 with other fields 0 → gain goes 8,16,24,32 at 4-cycle spacing, then `cfg_done` pulses once.
3. **Full retune.** Settled at gain 0x20, phase 0x1000. Accept phase=0x2000, gain=0x18 → gain ramps to 0, then phase becomes 0x2000 while gain=0. Gain stays 0 for 1+10+4 cycles, then ramps to 0x18, then `cfg_done`.
4. **Mute.** Assert mute at gain 0x20 in IDLE → ramps to 0, no `cfg_done`. Release mute → ramps back to 0x20. Assert mute mid-TRACK → the ramp reverses.
5. **Handshake.** Hold `cfg_valid` high while busy → no second accept until `cfg_ready`. Change the request data while not ready → the shadow is unchanged.
6. **Saturation.** Ramp 0x03→0xFF with GAIN_STEP=8 → final step lands exactly at 0xFF, no wrap. An identical request → `cfg_done` 2 cycles after accept.

Source files
------------

// File: rtl/tx_ctrl_pkg.sv
// Shared types, field widths and the saturating gain-step helper for the
// tx_core configuration sequencer.
package tx_ctrl_pkg;

  localparam int GAIN_W  = 8;
  localparam int PHASE_W = 16;
  localparam int PD_W    = 1;
  localparam int SCALE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FADE_OUT = 3'd1,
    ST_APPLY    = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_TRACK    = 3'd4
  } tx_seq_state_t;

  typedef struct packed {
    logic [GAIN_W-1:0]  gain;
    logic [PHASE_W-1:0] phase_inc;
    logic [PD_W-1:0]    pre_distortion;
    logic [SCALE_W-1:0] scale;
  } tx_cfg_t;

  // One ramp step toward target: lands exactly on target when within one
  // step, so the result can neither overshoot nor wrap.
  function automatic logic [GAIN_W-1:0] ramp_step(
    input logic [GAIN_W-1:0] gain,
    input logic [GAIN_W-1:0] target,
    input logic [GAIN_W-1:0] step
  );
    logic [GAIN_W-1:0] diff;
    if (target > gain) begin
      diff = target - gain;
      if (diff <= step) ramp_step = target;
      else              ramp_step = gain + step;
    end else begin
      diff = gain - target;
      if (diff <= step) ramp_step = target;
      else              ramp_step = gain - step;
    end
  endfunction

endpackage

// File: rtl/gain_ramp.sv
// Step timer plus saturating gain stepper. The timer reloads on start and
// fires one step every STEP_INTERVAL cycles while enabled.
module gain_ramp
  import tx_ctrl_pkg::*;
#(
  parameter int GAIN_STEP     = 1,
  parameter int STEP_INTERVAL = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              enable,
  input  logic [GAIN_W-1:0] target,
  input  logic [GAIN_W-1:0] gain,
  output logic [GAIN_W-1:0] gain_next,
  output logic              at_target
);

  localparam int TIMER_W = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(STEP_INTERVAL - 1);
  localparam logic [GAIN_W-1:0]  STEP_SIZE    = GAIN_W'(GAIN_STEP);

  logic [TIMER_W-1:0] timer_r;
  logic               step_s;

  // A step fires at terminal count while ramping; a reload suppresses it.
  always_comb begin
    step_s    = enable && !start && (timer_r == {TIMER_W{1'b0}});
    at_target = (gain == target);
    if (step_s) gain_next = ramp_step(gain, target, STEP_SIZE);
    else        gain_next = gain;
  end

  // Step interval counter: reload on entry and after every step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     timer_r <= TIMER_RELOAD;
    else if (start)   timer_r <= TIMER_RELOAD;
    else if (step_s)  timer_r <= TIMER_RELOAD;
    else if (enable)  timer_r <= timer_r - TIMER_W'(1);
    else              timer_r <= timer_r;
  end

endmodule

// File: rtl/tx_config_sequencer.sv
// Glitch-free run-time configuration sequencer for tx_core: fades gain out,
// applies new LO/pre-distortion/scale, waits for the path to flush, then
// ramps gain to the (mute-aware) target.
module tx_config_sequencer
  import tx_ctrl_pkg::*;
#(
  parameter int GAIN_STEP     = 1,
  parameter int STEP_INTERVAL = 16,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [GAIN_W-1:0]  cfg_mixer_gain,
  input  logic [PHASE_W-1:0] cfg_lo_dds_phase_inc,
  input  logic               cfg_enable_pre_distortion,
  input  logic [SCALE_W-1:0] cfg_scale_select,
  input  logic               mute_request,
  output logic               busy,
  output logic               cfg_done,
  output logic [GAIN_W-1:0]  mixer_gain,
  output logic [PHASE_W-1:0] lo_dds_phase_inc,
  output logic               enable_pre_distortion,
  output logic [SCALE_W-1:0] scale_select
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  tx_seq_state_t      state_r, state_s;
  tx_cfg_t            shadow_r;
  logic               pending_r;
  logic [SETTLE_W-1:0] settle_cnt_r;

  logic               accept_s, same_path_s, start_s, enable_s, at_target_s;
  logic [GAIN_W-1:0]  target_s, ramp_target_s, gain_next_s;
  logic [GAIN_W-1:0]  gain_d_s;
  logic [PHASE_W-1:0] phase_d_s;
  logic               pd_d_s, done_d_s, ready_d_s, busy_d_s;
  logic [SCALE_W-1:0] scale_d_s;

  // Handshake decode, effective target and ramp control.
  always_comb begin
    accept_s    = cfg_valid && cfg_ready;
    same_path_s = (cfg_lo_dds_phase_inc == lo_dds_phase_inc) &&
                  (cfg_enable_pre_distortion == enable_pre_distortion) &&
                  (cfg_scale_select == scale_select);
    if (mute_request) target_s = 8'd0;
    else              target_s = shadow_r.gain;
    if (state_r == ST_FADE_OUT) ramp_target_s = 8'd0;
    else                        ramp_target_s = target_s;
    enable_s = (state_r == ST_FADE_OUT) || (state_r == ST_TRACK);
    start_s  = ((state_s == ST_FADE_OUT) || (state_s == ST_TRACK)) && (state_s != state_r);
  end

  gain_ramp #(
    .GAIN_STEP     (GAIN_STEP),
    .STEP_INTERVAL (STEP_INTERVAL)
  ) u_gain_ramp (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start_s),
    .enable    (enable_s),
    .target    (ramp_target_s),
    .gain      (mixer_gain),
    .gain_next (gain_next_s),
    .at_target (at_target_s)
  );

  // Sequencer state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // Next-state logic; an accepted request outranks a mute mismatch in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (same_path_s) state_s = ST_TRACK;
          else             state_s = ST_FADE_OUT;
        end else if (mixer_gain != target_s) begin
          state_s = ST_TRACK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FADE_OUT: begin
        if (mixer_gain == 8'd0) state_s = ST_APPLY;
        else                    state_s = ST_FADE_OUT;
      end
      ST_APPLY: state_s = ST_SETTLE;
      ST_SETTLE: begin
        if (settle_cnt_r == {SETTLE_W{1'b0}}) state_s = ST_TRACK;
        else                                  state_s = ST_SETTLE;
      end
      ST_TRACK: begin
        if (at_target_s) state_s = ST_IDLE;
        else             state_s = ST_TRACK;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    gain_d_s  = mixer_gain;
    phase_d_s = lo_dds_phase_inc;
    pd_d_s    = enable_pre_distortion;
    scale_d_s = scale_select;
    case (state_r)
      ST_FADE_OUT, ST_TRACK: gain_d_s = gain_next_s;
      ST_APPLY: begin
        phase_d_s = shadow_r.phase_inc;
        pd_d_s    = shadow_r.pre_distortion;
        scale_d_s = shadow_r.scale;
      end
      default: gain_d_s = mixer_gain;
    endcase
    done_d_s  = (state_r == ST_TRACK) && (state_s == ST_IDLE) && pending_r;
    ready_d_s = (state_s == ST_IDLE);
    busy_d_s  = (state_s != ST_IDLE);
  end

  // Output registers toward tx_core and the request interface.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mixer_gain            <= 8'd0;
      lo_dds_phase_inc      <= 16'd0;
      enable_pre_distortion <= 1'b0;
      scale_select          <= 4'd0;
      cfg_done              <= 1'b0;
      cfg_ready             <= 1'b1;
      busy                  <= 1'b0;
    end else begin
      mixer_gain            <= gain_d_s;
      lo_dds_phase_inc      <= phase_d_s;
      enable_pre_distortion <= pd_d_s;
      scale_select          <= scale_d_s;
      cfg_done              <= done_d_s;
      cfg_ready             <= ready_d_s;
      busy                  <= busy_d_s;
    end
  end

  // Shadow of the last accepted request and its completion flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_r  <= '{gain: 8'd0, phase_inc: 16'd0, pre_distortion: 1'b0, scale: 4'd0};
      pending_r <= 1'b0;
    end else if (accept_s) begin
      shadow_r  <= '{gain: cfg_mixer_gain, phase_inc: cfg_lo_dds_phase_inc,
                     pre_distortion: cfg_enable_pre_distortion, scale: cfg_scale_select};
      pending_r <= 1'b1;
    end else if (done_d_s) begin
      shadow_r  <= shadow_r;
      pending_r <= 1'b0;
    end else begin
      shadow_r  <= shadow_r;
      pending_r <= pending_r;
    end
  end

  // Flush hold counter: loaded in APPLY, counts down through SETTLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      settle_cnt_r <= {SETTLE_W{1'b0}};
    else if (state_r == ST_APPLY)
      settle_cnt_r <= SETTLE_W'(SETTLE_CYCLES - 1);
    else if ((state_r == ST_SETTLE) && (settle_cnt_r != {SETTLE_W{1'b0}}))
      settle_cnt_r <= settle_cnt_r - SETTLE_W'(1);
    else
      settle_cnt_r <= settle_cnt_r;
  end

endmodule

// File: tb/tb_tx_config_sequencer.sv
// Self-checking bench for tx_config_sequencer (GAIN_STEP=8, STEP_INTERVAL=4,
// SETTLE_CYCLES=10). Scenario tasks push the expected gain trajectory into a
// queue; a negedge monitor pops and compares on every gain change.
module tb_tx_config_sequencer;

  logic        clock, reset_n;
  logic        cfg_valid, cfg_ready;
  logic [7:0]  cfg_mixer_gain;
  logic [15:0] cfg_lo_dds_phase_inc;
  logic        cfg_enable_pre_distortion;
  logic [3:0]  cfg_scale_select;
  logic        mute_request, busy, cfg_done;
  logic [7:0]  mixer_gain;
  logic [15:0] lo_dds_phase_inc;
  logic        enable_pre_distortion;
  logic [3:0]  scale_select;

  int checks = 0;
  int failures = 0;
  int done_count = 0;
  int accept_count = 0;
  logic [7:0] exp_gain_q[$];
  logic [7:0] prev_gain = 8'd0;

  tx_config_sequencer #(.GAIN_STEP(8), .STEP_INTERVAL(4), .SETTLE_CYCLES(10)) dut (
    .clock(clock), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mixer_gain(cfg_mixer_gain), .cfg_lo_dds_phase_inc(cfg_lo_dds_phase_inc),
    .cfg_enable_pre_distortion(cfg_enable_pre_distortion), .cfg_scale_select(cfg_scale_select),
    .mute_request(mute_request), .busy(busy), .cfg_done(cfg_done), .mixer_gain(mixer_gain),
    .lo_dds_phase_inc(lo_dds_phase_inc), .enable_pre_distortion(enable_pre_distortion),
    .scale_select(scale_select)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard consumer: every gain change must match the next expected value.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_gain = 8'd0;
    end else begin
      if (mixer_gain !== prev_gain) begin
        checks++;
        if (exp_gain_q.size() == 0) begin
          failures++;
          $display("FAIL gain_step: observed %0h, required no change (queue empty)", mixer_gain);
        end else begin
          logic [7:0] e;
          e = exp_gain_q.pop_front();
          if (mixer_gain !== e) begin
            failures++;
            $display("FAIL gain_step: observed %0h, required %0h", mixer_gain, e);
          end
        end
        prev_gain = mixer_gain;
      end
      if (cfg_done === 1'b1) done_count++;
    end
  end

  always @(posedge clock) begin
    if (reset_n && cfg_valid && cfg_ready) accept_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_ramp(input int from, input int to);
    int g;
    g = from;
    while (g != to) begin
      if (to > g) g = (to - g <= 8) ? to : g + 8;
      else        g = (g - to <= 8) ? to : g - 8;
      exp_gain_q.push_back(8'(g));
    end
  endtask

  task automatic send_cfg(input logic [7:0] g, input logic [15:0] ph, input logic pd, input logic [3:0] sc);
    cfg_mixer_gain = g; cfg_lo_dds_phase_inc = ph;
    cfg_enable_pre_distortion = pd; cfg_scale_select = sc;
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_gain(input logic [7:0] g, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (mixer_gain === g) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok;
    int d0;
    reset_n = 1'b0;
    tick(3);
    checks++;
    if ({mixer_gain, lo_dds_phase_inc, enable_pre_distortion, scale_select, cfg_done, busy} !== 31'd0) begin
      failures++; $display("FAIL reset_outputs: observed gain %0h phase %0h busy %0b, required all 0", mixer_gain, lo_dds_phase_inc, busy);
    end
    reset_n = 1'b1;
    tick(1);
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_release: observed ready %0b busy %0b, required 1 0", cfg_ready, busy);
    end
    d0 = done_count;
    push_ramp(0, 8'h40);
    send_cfg(8'h40, 16'h0000, 1'b0, 4'd0);
    wait_gain(8'd16, 50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL reset_ramp_wait: observed %0h, required 10", mixer_gain); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (mixer_gain !== 8'd0 || busy !== 1'b0 || cfg_done !== 1'b0) begin
      failures++; $display("FAIL reset_async: observed gain %0h busy %0b, required 0 0", mixer_gain, busy);
    end
    exp_gain_q.delete();
    tick(2);
    reset_n = 1'b1;
    tick(20);
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || mixer_gain !== 8'd0 || done_count != d0) begin
      failures++; $display("FAIL reset_abort: observed ready %0b busy %0b gain %0h dones %0d, required 1 0 0 0",
                           cfg_ready, busy, mixer_gain, done_count - d0);
    end
  endtask

  task automatic test_gain_only();
    bit ok;
    int d0;
    d0 = done_count;
    push_ramp(0, 8'h20);
    send_cfg(8'h20, 16'h0000, 1'b0, 4'd0);
    checks++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      failures++; $display("FAIL accept_state: observed busy %0b ready %0b, required 1 0", busy, cfg_ready);
    end
    tick(3);
    checks++;
    if (mixer_gain !== 8'd0) begin failures++; $display("FAIL step_early: observed %0h, required 0", mixer_gain); end
    tick(1);
    checks++;
    if (mixer_gain !== 8'd8) begin failures++; $display("FAIL step_first: observed %0h, required 8", mixer_gain); end
    tick(3);
    checks++;
    if (mixer_gain !== 8'd8) begin failures++; $display("FAIL step_spacing: observed %0h, required 8", mixer_gain); end
    wait_idle(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL gain_only_timeout: observed busy %0b, required 0", busy); end
    tick(3);
    checks++;
    if (mixer_gain !== 8'h20 || done_count - d0 != 1 || exp_gain_q.size() != 0) begin
      failures++; $display("FAIL gain_only_done: observed gain %0h dones %0d left %0d, required 20 1 0",
                           mixer_gain, done_count - d0, exp_gain_q.size());
    end
  endtask

  task automatic test_full_retune();
    bit ok, seen;
    int zero_total, zero_new, d0;
    logic [7:0] gain_at_phase;
    push_ramp(8'h20, 0); push_ramp(0, 8'h20);
    send_cfg(8'h20, 16'h1000, 1'b0, 4'd0);
    wait_idle(200, ok);
    tick(2);
    checks++;
    if (!ok || lo_dds_phase_inc !== 16'h1000 || mixer_gain !== 8'h20) begin
      failures++; $display("FAIL retune_setup: observed phase %0h gain %0h, required 1000 20", lo_dds_phase_inc, mixer_gain);
    end
    d0 = done_count;
    push_ramp(8'h20, 0); push_ramp(0, 8'h18);
    send_cfg(8'h18, 16'h2000, 1'b0, 4'd0);
    zero_total = 0; zero_new = 0; seen = 1'b0; gain_at_phase = 8'hFF; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (!seen && lo_dds_phase_inc === 16'h2000) begin seen = 1'b1; gain_at_phase = mixer_gain; end
      if (mixer_gain === 8'd0) begin
        zero_total++;
        if (lo_dds_phase_inc === 16'h2000) zero_new++;
      end
      if (!busy) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || gain_at_phase !== 8'd0) begin
      failures++; $display("FAIL retune_apply: observed gain at phase change %0h, required 0", gain_at_phase);
    end
    // Zero-gain run: last FADE_OUT cycle + APPLY + 10 settle + 4 before first step.
    checks++;
    if (zero_total != 16 || zero_new != 14) begin
      failures++; $display("FAIL retune_zero_hold: observed %0d/%0d, required 16/14", zero_total, zero_new);
    end
    tick(2);
    checks++;
    if (mixer_gain !== 8'h18 || done_count - d0 != 1 || exp_gain_q.size() != 0) begin
      failures++; $display("FAIL retune_done: observed gain %0h dones %0d, required 18 1", mixer_gain, done_count - d0);
    end
  endtask

  task automatic test_mute();
    bit ok;
    int d0;
    push_ramp(8'h18, 8'h20);
    send_cfg(8'h20, 16'h2000, 1'b0, 4'd0);
    wait_idle(100, ok);
    tick(2);
    d0 = done_count;
    push_ramp(8'h20, 0);
    mute_request = 1'b1;
    wait_idle(100, ok);
    tick(2);
    checks++;
    if (!ok || mixer_gain !== 8'd0 || done_count != d0) begin
      failures++; $display("FAIL mute_down: observed gain %0h dones %0d, required 0 0", mixer_gain, done_count - d0);
    end
    push_ramp(0, 16);
    mute_request = 1'b0;
    wait_gain(8'd16, 50, ok);
    push_ramp(16, 0);
    mute_request = 1'b1;
    wait_idle(100, ok);
    tick(2);
    checks++;
    if (!ok || mixer_gain !== 8'd0 || exp_gain_q.size() != 0) begin
      failures++; $display("FAIL mute_reverse: observed gain %0h left %0d, required 0 0", mixer_gain, exp_gain_q.size());
    end
    push_ramp(0, 8'h20);
    mute_request = 1'b0;
    wait_idle(100, ok);
    tick(2);
    checks++;
    if (!ok || mixer_gain !== 8'h20 || done_count != d0) begin
      failures++; $display("FAIL mute_release: observed gain %0h dones %0d, required 20 0", mixer_gain, done_count - d0);
    end
  endtask

  task automatic test_handshake();
    bit ok;
    int a0, overlap;
    a0 = accept_count;
    overlap = 0;
    push_ramp(8'h20, 8'h10);
    cfg_mixer_gain = 8'h10; cfg_lo_dds_phase_inc = 16'h2000;
    cfg_enable_pre_distortion = 1'b0; cfg_scale_select = 4'd0;
    cfg_valid = 1'b1;
    tick(1);
    cfg_mixer_gain = 8'h40; cfg_lo_dds_phase_inc = 16'h3000;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (busy && cfg_ready) overlap++;
      if (cfg_ready) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || overlap != 0 || accept_count - a0 != 1) begin
      failures++; $display("FAIL hs_busy: observed overlap %0d accepts %0d, required 0 1", overlap, accept_count - a0);
    end
    checks++;
    if (mixer_gain !== 8'h10 || lo_dds_phase_inc !== 16'h2000 || cfg_done !== 1'b1) begin
      failures++; $display("FAIL hs_shadow: observed gain %0h phase %0h done %0b, required 10 2000 1",
                           mixer_gain, lo_dds_phase_inc, cfg_done);
    end
    push_ramp(8'h10, 0); push_ramp(0, 8'h40);
    tick(1);
    cfg_valid = 1'b0;
    wait_idle(300, ok);
    tick(2);
    checks++;
    if (!ok || lo_dds_phase_inc !== 16'h3000 || mixer_gain !== 8'h40 || accept_count - a0 != 2) begin
      failures++; $display("FAIL hs_second: observed phase %0h gain %0h accepts %0d, required 3000 40 2",
                           lo_dds_phase_inc, mixer_gain, accept_count - a0);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    push_ramp(8'h40, 8'h03);
    send_cfg(8'h03, 16'h3000, 1'b0, 4'd0);
    wait_idle(100, ok);
    tick(2);
    checks++;
    if (!ok || mixer_gain !== 8'h03) begin failures++; $display("FAIL sat_low: observed %0h, required 3", mixer_gain); end
    push_ramp(8'h03, 8'hFF);
    send_cfg(8'hFF, 16'h3000, 1'b0, 4'd0);
    wait_idle(300, ok);
    tick(2);
    checks++;
    if (!ok || mixer_gain !== 8'hFF || exp_gain_q.size() != 0) begin
      failures++; $display("FAIL sat_high: observed %0h left %0d, required ff 0", mixer_gain, exp_gain_q.size());
    end
  endtask

  task automatic test_back_to_back();
    send_cfg(8'hFF, 16'h3000, 1'b0, 4'd0);
    checks++;
    if (cfg_done !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL ident_c1: observed done %0b busy %0b, required 0 1", cfg_done, busy);
    end
    tick(1);
    checks++;
    if (cfg_done !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL ident_c2: observed done %0b ready %0b, required 1 1", cfg_done, cfg_ready);
    end
    tick(1);
    checks++;
    if (cfg_done !== 1'b0 || mixer_gain !== 8'hFF) begin
      failures++; $display("FAIL ident_c3: observed done %0b gain %0h, required 0 ff", cfg_done, mixer_gain);
    end
  endtask

  initial begin
    reset_n = 1'b0; cfg_valid = 1'b0; mute_request = 1'b0;
    cfg_mixer_gain = 8'd0; cfg_lo_dds_phase_inc = 16'd0;
    cfg_enable_pre_distortion = 1'b0; cfg_scale_select = 4'd0;
    test_reset();
    test_gain_only();
    test_full_retune();
    test_mute();
    test_handshake();
    test_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
